// File: rtl/button_conditioner_if.sv
// Push-button bundle between the board pins and the conditioner: raw levels in,
// debounced level and press/release/repeat pulses out.
interface button_conditioner_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_db;
    logic [NUM_BTN-1:0] btn_scen;
    logic [NUM_BTN-1:0] btn_rel;
    logic [NUM_BTN-1:0] btn_mcen;

    modport master (output btn_raw, input btn_db, btn_scen, btn_rel, btn_mcen);
    modport slave  (input btn_raw, output btn_db, btn_scen, btn_rel, btn_mcen);
endinterface

// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: 2-flop synchroniser, debounce FSM and registered
// level/press/release outputs. Define BTN_AUTOREPEAT_EN to add auto-repeat pulses on btn_mcen.
module button_conditioner #(
    parameter int NUM_BTN       = 5,
    parameter int DEB_CYCLES    = 1000000,
    parameter int CNT_W         = 20,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  btn_if
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2 || (64'(1) << CNT_W) < 64'(DEB_CYCLES) ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: illegal parameter combination");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] HOLD_LAST   = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REPEAT_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_if.btn_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_q, db_d;
            logic             scen_q, scen_d;
            logic             rel_q, rel_d;
            logic             mcen_q, mcen_d;
            logic             in_lvl;

            assign in_lvl = sync2_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // A disagreeing sample abandons the debounce and returns to the settled state.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    IDLE: begin
                        if (in_lvl) begin
                            state_d = DEB_PRESS;
                            cnt_d   = '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!in_lvl)                 state_d = IDLE;
                        else if (cnt_q == DEB_LAST)  state_d = PRESSED;
                        else                         cnt_d   = cnt_q + CNT_W'(1);
                    end
                    PRESSED: begin
                        if (!in_lvl) begin
                            state_d = DEB_RELEASE;
                            cnt_d   = '0;
                        end
                    end
                    DEB_RELEASE: begin
                        if (in_lvl)                  state_d = PRESSED;
                        else if (cnt_q == DEB_LAST)  state_d = IDLE;
                        else                         cnt_d   = cnt_q + CNT_W'(1);
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_comb begin
                db_d   = (state_d == PRESSED) || (state_d == DEB_RELEASE);
                scen_d = (state_q == DEB_PRESS) && (state_d == PRESSED);
                rel_d  = (state_q == DEB_RELEASE) && (state_d == IDLE);
            end

`ifdef BTN_AUTOREPEAT_EN
            logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
            logic             rep_phase_q, rep_phase_d;
            logic             rep_fire;

            // rep_phase_q selects the initial hold delay (0) or the steady repeat period (1).
            always_comb begin
                rep_cnt_d   = rep_cnt_q;
                rep_phase_d = rep_phase_q;
                rep_fire    = 1'b0;
                if (scen_d || !db_d) begin
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b0;
                end else if (rep_cnt_q == (rep_phase_q ? REPEAT_LAST : HOLD_LAST)) begin
                    rep_fire    = 1'b1;
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rep_cnt_q   <= '0;
                    rep_phase_q <= 1'b0;
                end else begin
                    rep_cnt_q   <= rep_cnt_d;
                    rep_phase_q <= rep_phase_d;
                end
            end

            assign mcen_d = scen_d | rep_fire;
`else
            assign mcen_d = scen_d;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    db_q   <= 1'b0;
                    scen_q <= 1'b0;
                    rel_q  <= 1'b0;
                    mcen_q <= 1'b0;
                end else begin
                    db_q   <= db_d;
                    scen_q <= scen_d;
                    rel_q  <= rel_d;
                    mcen_q <= mcen_d;
                end
            end

            assign btn_if.btn_db[gi]   = db_q;
            assign btn_if.btn_scen[gi] = scen_q;
            assign btn_if.btn_rel[gi]  = rel_q;
            assign btn_if.btn_mcen[gi] = mcen_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, hand-written latency/reset/repeat sequences,
// and randomized levels checked every cycle against a run-length debounce model.
module tb_button_conditioner;

    localparam int NB     = 5;
    localparam int DEB    = 4;
    localparam int HOLD   = 20;
    localparam int REPEAT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(NB)) bif ();

    button_conditioner #(
        .NUM_BTN      (NB),
        .DEB_CYCLES   (DEB),
        .CNT_W        (3),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_if (bif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: debounced level flips once the synchronised input has disagreed
    // with it for DEB+1 consecutive clock edges.
    logic [NB-1:0] m_sync1 = '0, m_sync2 = '0;
    bit   [NB-1:0] m_db = '0;
    int            m_run [NB];
    int            m_age [NB];
    logic [NB-1:0] exp_db, exp_scen, exp_rel, exp_mcen;
    int            scen_cnt [NB];
    int            rel_cnt  [NB];

    typedef struct {
        logic [NB-1:0] raw;
        int            hold;
        logic [NB-1:0] exp_db;
        logic [NB-1:0] exp_scen;
        logic [NB-1:0] exp_rel;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic [NB-1:0] raw, input logic r);
        logic [NB-1:0] s_now;
        if (r) begin
            m_sync1 = '0;
            m_sync2 = '0;
            m_db    = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end
            exp_db = '0; exp_scen = '0; exp_rel = '0; exp_mcen = '0;
        end else begin
            s_now   = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = raw;
            exp_scen = '0; exp_rel = '0; exp_mcen = '0;
            for (int i = 0; i < NB; i++) begin
                if (s_now[i] != m_db[i]) m_run[i]++;
                else                     m_run[i] = 0;
                if (m_run[i] == DEB + 1) begin
                    m_db[i]  = !m_db[i];
                    m_run[i] = 0;
                    if (m_db[i]) exp_scen[i] = 1'b1;
                    else         exp_rel[i]  = 1'b1;
                end
                if (m_db[i]) m_age[i] = exp_scen[i] ? 0 : m_age[i] + 1;
                else         m_age[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                exp_mcen[i] = m_db[i] && ((m_age[i] == 0) ||
                              (m_age[i] >= HOLD && ((m_age[i] - HOLD) % REPEAT) == 0));
`else
                exp_mcen[i] = exp_scen[i];
`endif
            end
            exp_db = m_db;
        end
    endtask

    task automatic cycle(input logic [NB-1:0] raw, input logic r);
        @(negedge clk);
        bif.btn_raw = raw;
        rst         = r;
        @(posedge clk);
        model_step(raw, r);
        #1;
        check("cyc db",   32'(bif.btn_db),   32'(exp_db));
        check("cyc scen", 32'(bif.btn_scen), 32'(exp_scen));
        check("cyc rel",  32'(bif.btn_rel),  32'(exp_rel));
        check("cyc mcen", 32'(bif.btn_mcen), 32'(exp_mcen));
        for (int i = 0; i < NB; i++) begin
            if (bif.btn_scen[i]) scen_cnt[i]++;
            if (bif.btn_rel[i])  rel_cnt[i]++;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            scen_cnt[i] = 0;
            rel_cnt[i]  = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] act_scen, act_rel, r;
        logic          dup;
        int            offs [$];
        int            exp_offs [$];
        bit            found;

        bif.btn_raw = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
        clear_counts();

        vecs[0] = '{5'b00000,  4, 5'b00000, 5'b00000, 5'b00000};
        vecs[1] = '{5'b00010,  3, 5'b00000, 5'b00000, 5'b00000}; // short pulse is rejected
        vecs[2] = '{5'b00000,  8, 5'b00000, 5'b00000, 5'b00000};
        vecs[3] = '{5'b10001,  8, 5'b10001, 5'b10001, 5'b00000};
        vecs[4] = '{5'b00000,  8, 5'b00000, 5'b00000, 5'b10001};
        vecs[5] = '{5'b00100, 15, 5'b00100, 5'b00100, 5'b00000};
        vecs[6] = '{5'b00000,  2, 5'b00100, 5'b00000, 5'b00000}; // low glitch while held
        vecs[7] = '{5'b00100, 13, 5'b00100, 5'b00000, 5'b00000};

        // Reset state
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        check("reset db",   32'(bif.btn_db),   32'd0);
        check("reset scen", 32'(bif.btn_scen), 32'd0);
        check("reset rel",  32'(bif.btn_rel),  32'd0);
        check("reset mcen", 32'(bif.btn_mcen), 32'd0);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            clear_counts();
            for (int c = 0; c < vecs[v].hold; c++) cycle(vecs[v].raw, 1'b0);
            dup = 1'b0;
            for (int i = 0; i < NB; i++) begin
                act_scen[i] = (scen_cnt[i] != 0);
                act_rel[i]  = (rel_cnt[i] != 0);
                if (scen_cnt[i] > 1 || rel_cnt[i] > 1) dup = 1'b1;
            end
            check("vec scen", 32'(act_scen), 32'(vecs[v].exp_scen));
            check("vec rel",  32'(act_rel),  32'(vecs[v].exp_rel));
            check("vec db",   32'(bif.btn_db), 32'(vecs[v].exp_db));
            check("vec dup",  32'(dup), 32'd0);
            $display("vec %0d raw=%b hold=%0d db=%b scen=%b rel=%b", v, vecs[v].raw,
                     vecs[v].hold, bif.btn_db, act_scen, act_rel);
        end
        // Release channel 2: exactly one release pulse 6 edges after first low sample
        clear_counts();
        for (int n = 0; n < 8; n++) begin
            cycle('0, 1'b0);
            check("glitch rel2", 32'(bif.btn_rel[2]), 32'(n == 6));
        end
        check("glitch rel2 count", 32'(rel_cnt[2]), 32'd1);
        $display("seq glitch-release ch2 rel_count=%0d", rel_cnt[2]);

        // Press latency on channel 0
        idle(4);
        for (int n = 0; n < 8; n++) begin
            cycle(5'b00001, 1'b0);
            check("lat scen0", 32'(bif.btn_scen[0]), 32'(n == 6));
            check("lat db0",   32'(bif.btn_db[0]),   32'(n >= 6));
        end
        for (int n = 0; n < 8; n++) begin
            cycle('0, 1'b0);
            check("lat rel0", 32'(bif.btn_rel[0]), 32'(n == 6));
            check("lat rdb0", 32'(bif.btn_db[0]),  32'(n < 6));
        end
        $display("seq latency ch0 db=%b", bif.btn_db);

        // Reset while channel 3 is pressed and held
        idle(4);
        for (int n = 0; n < 8; n++) cycle(5'b01000, 1'b0);
        check("rst pre db3", 32'(bif.btn_db[3]), 32'd1);
        clear_counts();
        cycle(5'b01000, 1'b1);
        check("rst db",   32'(bif.btn_db),   32'd0);
        check("rst scen", 32'(bif.btn_scen), 32'd0);
        check("rst rel",  32'(bif.btn_rel),  32'd0);
        check("rst mcen", 32'(bif.btn_mcen), 32'd0);
        for (int n = 0; n < 8; n++) begin
            cycle(5'b01000, 1'b0);
            check("rst scen3", 32'(bif.btn_scen[3]), 32'(n == 6));
        end
        check("rst no rel3", 32'(rel_cnt[3]), 32'd0);
        $display("seq reset ch3 scen_count=%0d rel_count=%0d", scen_cnt[3], rel_cnt[3]);
        idle(10);

        // Auto-repeat offsets on channel 0
`ifdef BTN_AUTOREPEAT_EN
        exp_offs = '{0, 20, 28, 36, 44};
`else
        exp_offs = '{0};
`endif
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(5'b00001, 1'b0);
            if (bif.btn_scen[0]) begin
                found = 1'b1;
                if (bif.btn_mcen[0]) offs.push_back(0);
            end
        end
        check("rep press seen", 32'(found), 32'd1);
        for (int off = 1; off <= 50; off++) begin
            cycle(5'b00001, 1'b0);
            if (bif.btn_mcen[0]) offs.push_back(off);
        end
        check("rep count", 32'(offs.size()), 32'(exp_offs.size()));
        for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
            check("rep offset", 32'(offs[i]), 32'(exp_offs[i]));
        $display("seq autorepeat ch0 pulses=%0d", offs.size());
        idle(10);

        // Randomized levels against the model
        r = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 6) == 0) r[i] = ~r[i];
            cycle(r, ($urandom_range(0, 199) == 0));
        end
        $display("seq random 800 cycles done, failures so far=%0d", n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
